// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DMA  = 1'b1;

    // Saturating 4-bit increment; the starvation counter never exceeds lim.
    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of one arbiter port: request/command toward memory, grant and read return back.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/arb_grant.sv
// Core-first grant with a starvation counter that forces one DMA slot after STARVE_MAX denials.
module arb_grant
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic core_req,
    input  logic dma_req,
    output logic core_gnt,
    output logic dma_gnt
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_reg;

    always_comb begin
        dma_gnt  = run & dma_req & (~core_req | (starve_cnt_reg == STARVE_LIM));
        core_gnt = run & core_req & ~dma_gnt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_reg <= '0;
        end else if (!dma_req || dma_gnt) begin
            starve_cnt_reg <= '0;
        end else if (run) begin
            starve_cnt_reg <= sat_inc(starve_cnt_reg, STARVE_LIM);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a core port and a DMA port onto one synchronous-read data memory,
// with an IDLE/RUN/DRAIN run controller and single-entry read-return tracking.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    mem_arbiter_if.slave      core,
    mem_arbiter_if.slave      dma,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t        state_reg;
    logic              pending_reg;
    logic              owner_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic              run;
    logic              core_gnt;
    logic              dma_gnt;
    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              pending_next;
    logic              core_rvalid;
    logic              dma_rvalid;

    assign run = (state_reg == RUN);

    arb_grant #(
        .STARVE_MAX(STARVE_MAX)
    ) u_grant (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .core_req (core.req),
        .dma_req  (dma.req),
        .core_gnt (core_gnt),
        .dma_gnt  (dma_gnt)
    );

    always_comb begin
        any_gnt      = core_gnt | dma_gnt;
        sel_we       = dma_gnt ? dma.we    : core.we;
        sel_addr     = dma_gnt ? dma.addr  : core.addr;
        sel_wdata    = dma_gnt ? dma.wdata : core.wdata;
        mem_we       = any_gnt & sel_we;
        // Without a grant the memory bus parks on the last issued command.
        mem_addr     = any_gnt ? sel_addr  : addr_reg;
        mem_wdata    = any_gnt ? sel_wdata : wdata_reg;
        pending_next = any_gnt & ~sel_we;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            pending_reg <= 1'b0;
            owner_reg   <= PORT_CORE;
            addr_reg    <= '0;
            wdata_reg   <= '0;
        end else begin
            pending_reg <= pending_next;
            if (any_gnt) begin
                owner_reg <= dma_gnt ? PORT_DMA : PORT_CORE;
                addr_reg  <= sel_addr;
                wdata_reg <= sel_wdata;
            end
            case (state_reg)
                IDLE:    if (start) state_reg <= RUN;
                RUN:     if (!start) state_reg <= DRAIN;
                // The read issued on the last RUN cycle returns during DRAIN itself.
                DRAIN:   if (!pending_next) state_reg <= start ? RUN : IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign core_rvalid = pending_reg & (owner_reg == PORT_CORE);
    assign dma_rvalid  = pending_reg & (owner_reg == PORT_DMA);

    assign core.gnt    = core_gnt;
    assign dma.gnt     = dma_gnt;
    assign core.rvalid = core_rvalid;
    assign dma.rvalid  = dma_rvalid;
    assign core.rdata  = core_rvalid ? mem_rdata : '0;
    assign dma.rdata   = dma_rvalid  ? mem_rdata : '0;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: fixed vector table, hand sequences for
// starvation / drain / reset, and random traffic against a queue-based reference model.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          start    = 1'b0;
    logic          mem_init = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic [DW-1:0] mem [0:255];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) core_if ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dma_if ();

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .core      (core_if),
        .dma       (dma_if),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Synchronous-read memory behind the arbiter.
    always @(posedge clk) begin
        if (mem_init) begin
            mem_rdata <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
        end else begin
            mem_rdata <= mem[mem_addr[7:0]];
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit          port;
        logic [31:0] data;
    } ret_t;

    int          m_mode;      // 0 idle, 1 run, 2 drain
    int          m_starve;
    ret_t        ret_q[$];
    logic [31:0] m_last_addr;
    logic [31:0] m_last_wdata;
    logic [31:0] shadow [0:255];
    bit          e_cgnt;
    bit          e_dgnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode       = 0;
        m_starve     = 0;
        ret_q.delete();
        m_last_addr  = '0;
        m_last_wdata = '0;
    endtask

    task automatic model_check();
        bit          e_we;
        logic [31:0] e_addr;
        bit          e_rvc;
        bit          e_rvd;
        logic [31:0] e_rd;
        if (!reset) model_reset();
        e_dgnt = (m_mode == 1) && dma_if.req && (!core_if.req || m_starve >= SMAX);
        e_cgnt = (m_mode == 1) && core_if.req && !e_dgnt;
        e_we   = e_cgnt ? core_if.we : (e_dgnt ? dma_if.we : 1'b0);
        e_addr = e_cgnt ? core_if.addr : (e_dgnt ? dma_if.addr : m_last_addr);
        e_rvc  = 1'b0;
        e_rvd  = 1'b0;
        e_rd   = '0;
        if (ret_q.size() > 0) begin
            e_rvc = (ret_q[0].port == 1'b0);
            e_rvd = (ret_q[0].port == 1'b1);
            e_rd  = ret_q[0].data;
        end
        chk("core_gnt", core_if.gnt, e_cgnt);
        chk("dma_gnt", dma_if.gnt, e_dgnt);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        if (e_cgnt || e_dgnt) chk("mem_wdata", mem_wdata, e_cgnt ? core_if.wdata : dma_if.wdata);
        chk("core_rvalid", core_if.rvalid, e_rvc);
        chk("dma_rvalid", dma_if.rvalid, e_rvd);
        if (e_rvc) chk("core_rdata", core_if.rdata, e_rd);
        if (e_rvd) chk("dma_rdata", dma_if.rdata, e_rd);
        chk("busy", busy, m_mode != 0);
        if (!reset) begin
            chk("rst_core_rdata", core_if.rdata, 0);
            chk("rst_dma_rdata", dma_if.rdata, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
        end
    endtask

    task automatic model_update();
        bit          p;
        logic [31:0] a;
        logic [31:0] d;
        bit          w;
        if (!reset) begin
            model_reset();
            return;
        end
        if (ret_q.size() > 0) ret_q.delete(0);
        if (e_cgnt || e_dgnt) begin
            p = e_dgnt;
            a = p ? dma_if.addr  : core_if.addr;
            d = p ? dma_if.wdata : core_if.wdata;
            w = p ? dma_if.we    : core_if.we;
            m_last_addr  = a;
            m_last_wdata = d;
            if (w) shadow[a[7:0]] = d;
            else   ret_q.push_back(ret_t'{p, shadow[a[7:0]]});
        end
        if (!dma_if.req || e_dgnt)              m_starve = 0;
        else if (m_mode == 1 && m_starve < SMAX) m_starve++;
        case (m_mode)
            0: if (start) m_mode = 1;
            1: if (!start) m_mode = 2;
            default: if (ret_q.size() == 0) m_mode = start ? 1 : 0;
        endcase
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input bit s, input bit cr, input bit cw, input logic [31:0] ca,
                         input logic [31:0] cd, input bit dr, input bit dw,
                         input logic [31:0] da, input logic [31:0] dd);
        start         = s;
        core_if.req   = cr;
        core_if.we    = cw;
        core_if.addr  = ca;
        core_if.wdata = cd;
        dma_if.req    = dr;
        dma_if.we     = dw;
        dma_if.addr   = da;
        dma_if.wdata  = dd;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          s, cr, cw;
        logic [31:0] ca, cd;
        bit          dr, dw;
        logic [31:0] da;
        bit          e_cg, e_dg, e_mwe, e_crv, e_drv, e_busy;
        logic [31:0] e_rd;
    } vec_t;

    function automatic vec_t mk(bit s, bit cr, bit cw, logic [31:0] ca, logic [31:0] cd,
                                bit dr, bit dw, logic [31:0] da, bit cg, bit dg, bit mwe,
                                bit crv, bit drv, bit b, logic [31:0] rd);
        vec_t v;
        v.s = s; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.da = da;
        v.e_cg = cg; v.e_dg = dg; v.e_mwe = mwe; v.e_crv = crv; v.e_drv = drv;
        v.e_busy = b; v.e_rd = rd;
        return v;
    endfunction

    vec_t vt[12];

    initial begin
        bit          c_seen;
        bit          d_seen;
        bit          c_req, c_we, d_req, d_we;
        logic [31:0] c_addr, c_wd, d_addr, d_wd;

        for (int i = 0; i < 256; i++) shadow[i] = 32'hA000_0000 | 32'(i);
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        settle();
        chk("reset_busy", busy, 0);
        chk("reset_mem_addr", mem_addr, 0);
        tick();
        settle();
        tick();
        mem_init = 1'b0;
        reset    = 1'b1;

        //        s  cr cw ca        cd  dr dw da     cg dg mwe crv drv busy rdata
        vt[0]  = mk(0, 0, 0, 0,        0, 0, 0, 0,     0, 0, 0,  0,  0,  0,  0);
        vt[1]  = mk(1, 0, 0, 0,        0, 0, 0, 0,     0, 0, 0,  0,  0,  0,  0);
        vt[2]  = mk(1, 1, 0, 32'h64,   0, 0, 0, 0,     1, 0, 0,  0,  0,  1,  0);
        vt[3]  = mk(1, 0, 0, 0,        0, 0, 0, 0,     0, 0, 0,  1,  0,  1,  32'hA000_0064);
        vt[4]  = mk(1, 1, 1, 32'h64,   7, 0, 0, 0,     1, 0, 1,  0,  0,  1,  0);
        vt[5]  = mk(1, 0, 0, 0,        0, 1, 0, 32'h64, 0, 1, 0, 0,  0,  1,  0);
        vt[6]  = mk(1, 0, 0, 0,        0, 0, 0, 0,     0, 0, 0,  0,  1,  1,  7);
        vt[7]  = mk(1, 1, 0, 32'h0,    0, 0, 0, 0,     1, 0, 0,  0,  0,  1,  0);
        vt[8]  = mk(1, 0, 0, 0,        0, 1, 0, 32'h4, 0, 1, 0,  1,  0,  1,  32'hA000_0000);
        vt[9]  = mk(1, 1, 0, 32'h0,    0, 0, 0, 0,     1, 0, 0,  0,  1,  1,  32'hA000_0004);
        vt[10] = mk(1, 0, 0, 0,        0, 1, 0, 32'h4, 0, 1, 0,  1,  0,  1,  32'hA000_0000);
        vt[11] = mk(1, 0, 0, 0,        0, 0, 0, 0,     0, 0, 0,  0,  1,  1,  32'hA000_0004);

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].s, vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd, vt[i].dr, vt[i].dw, vt[i].da, 0);
            settle();
            chk($sformatf("vec%0d_core_gnt", i), core_if.gnt, vt[i].e_cg);
            chk($sformatf("vec%0d_dma_gnt", i), dma_if.gnt, vt[i].e_dg);
            chk($sformatf("vec%0d_mem_we", i), mem_we, vt[i].e_mwe);
            chk($sformatf("vec%0d_core_rvalid", i), core_if.rvalid, vt[i].e_crv);
            chk($sformatf("vec%0d_dma_rvalid", i), dma_if.rvalid, vt[i].e_drv);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
            if (vt[i].e_crv) chk($sformatf("vec%0d_core_rdata", i), core_if.rdata, vt[i].e_rd);
            if (vt[i].e_drv) chk($sformatf("vec%0d_dma_rdata", i), dma_if.rdata, vt[i].e_rd);
            $display("vec %0d: cgnt=%0b dgnt=%0b crv=%0b drv=%0b busy=%0b", i,
                     core_if.gnt, dma_if.gnt, core_if.rvalid, dma_if.rvalid, busy);
            tick();
        end

        // Both ports requesting continuously: four core slots, then one forced DMA slot.
        drive(1, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
        for (int k = 0; k < 15; k++) begin
            settle();
            chk($sformatf("starve%0d_dma_gnt", k), dma_if.gnt, (k % 5) == 4);
            chk($sformatf("starve%0d_core_gnt", k), core_if.gnt, (k % 5) != 4);
            $display("starve cycle %0d: cgnt=%0b dgnt=%0b", k, core_if.gnt, dma_if.gnt);
            tick();
        end

        // Core read granted on the cycle start falls, then drain and idle.
        drive(0, 1, 0, 32'h8, 0, 0, 0, 0, 0);
        settle();
        chk("drain_grant_core_gnt", core_if.gnt, 1);
        chk("drain_grant_busy", busy, 1);
        tick();
        drive(0, 1, 1, 32'h8, 32'h55, 0, 0, 0, 0);
        settle();
        chk("drain_core_rvalid", core_if.rvalid, 1);
        chk("drain_core_rdata", core_if.rdata, 32'hA000_0008);
        chk("drain_no_gnt", core_if.gnt, 0);
        chk("drain_no_we", mem_we, 0);
        chk("drain_busy", busy, 1);
        tick();
        settle();
        chk("drain_idle_busy", busy, 0);
        chk("drain_idle_rvalid", core_if.rvalid, 0);
        $display("drain sequence: busy=%0b", busy);
        tick();

        // Reset asserted while a read return is pending.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        tick();
        drive(1, 1, 0, 32'h64, 0, 0, 0, 0, 0);
        settle();
        chk("rstmid_core_gnt", core_if.gnt, 1);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_core_rvalid", core_if.rvalid, 0);
        chk("rstmid_dma_rvalid", dma_if.rvalid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_mem_addr", mem_addr, 0);
        chk("rstmid_mem_wdata", mem_wdata, 0);
        chk("rstmid_core_rdata", core_if.rdata, 0);
        $display("reset mid-read: rvalid=%0b busy=%0b", core_if.rvalid, busy);
        settle();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("post_rst%0d_core_rvalid", k), core_if.rvalid, 0);
            tick();
        end

        // Random traffic; each requester holds its command until granted.
        c_req = 0; c_we = 0; c_addr = 0; c_wd = 0; c_seen = 1;
        d_req = 0; d_we = 0; d_addr = 0; d_wd = 0; d_seen = 1;
        for (int n = 0; n < 400; n++) begin
            if (!c_req || c_seen) begin
                c_req  = ($urandom_range(0, 99) < 60);
                c_we   = ($urandom_range(0, 2) == 0);
                c_addr = 32'($urandom_range(0, 15)) << 2;
                c_wd   = $urandom;
            end
            if (!d_req || d_seen) begin
                d_req  = ($urandom_range(0, 99) < 50);
                d_we   = ($urandom_range(0, 2) == 0);
                d_addr = 32'($urandom_range(0, 15)) << 2;
                d_wd   = $urandom;
            end
            drive($urandom_range(0, 15) != 0, c_req, c_we, c_addr, c_wd, d_req, d_we, d_addr, d_wd);
            settle();
            c_seen = core_if.gnt;
            d_seen = dma_if.gnt;
            $display("rand %0d: s=%0b creq=%0b dreq=%0b cgnt=%0b dgnt=%0b crv=%0b drv=%0b",
                     n, start, c_req, d_req, core_if.gnt, dma_if.gnt, core_if.rvalid, dma_if.rvalid);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
